// File: rtl/param_bank.sv
// Double-buffered parameter bank: bytes land in a shadow bank and are copied
// wholesale into the active bank at the first frame boundary after a packet completes.
module param_bank #(
  parameter int unsigned NUM_REGS = 55,
  parameter int unsigned IDX_W    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    update_reg,
  input  logic [IDX_W-1:0]        idx,
  input  logic [7:0]              read_data,
  input  logic                    pc_ready,
  input  logic                    frame_start,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [7:0]              rd_data,
  output logic [NUM_REGS*8-1:0]   params_flat,
  output logic                    commit_pending,
  output logic                    frame_applied,
  output logic [7:0]              commit_cnt,
  output logic [3:0]              overrun_cnt,
  output logic                    bad_idx
);

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [NUM_REGS-1:0][7:0]   r_shadow;
  logic [NUM_REGS-1:0][7:0]   r_active;
  logic [7:0]                 r_rd_data;
  logic [7:0]                 r_commit_cnt;
  logic [3:0]                 r_overrun_cnt;
  logic                       r_frame_applied;
  logic                       r_bad_idx;
  logic                       w_commit;
  logic                       w_overrun;
  logic                       w_wr_ok;
  logic                       w_rd_ok;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign w_wr_ok = 32'(idx) < NUM_REGS;
  assign w_rd_ok = 32'(rd_idx) < NUM_REGS;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (pc_ready && !frame_start) w_state_nxt = S_PENDING;
      S_PENDING: if (frame_start)              w_state_nxt = S_IDLE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // A pc_ready coinciding with frame_start commits at once instead of arming.
  always_comb begin
    commit_pending = (r_state == S_PENDING);
    w_commit       = frame_start && ((r_state == S_PENDING) || pc_ready);
    w_overrun      = pc_ready && (r_state == S_PENDING) && !frame_start;
  end

  // Copy reads the pre-write shadow, so a same-cycle write only reaches shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow        <= '0;
      r_active        <= '0;
      r_rd_data       <= '0;
      r_commit_cnt    <= '0;
      r_overrun_cnt   <= '0;
      r_frame_applied <= 1'b0;
      r_bad_idx       <= 1'b0;
    end else begin
      if (w_commit) r_active <= r_shadow;
      if (update_reg && w_wr_ok)  r_shadow[idx] <= read_data;
      if (update_reg && !w_wr_ok) r_bad_idx     <= 1'b1;
      r_rd_data       <= w_rd_ok ? r_active[rd_idx] : 8'h00;
      r_frame_applied <= w_commit;
      if (w_commit)  r_commit_cnt  <= r_commit_cnt + 8'd1;
      if (w_overrun) r_overrun_cnt <= sat_inc4(r_overrun_cnt);
    end
  end

  assign params_flat   = r_active;
  assign rd_data       = r_rd_data;
  assign frame_applied = r_frame_applied;
  assign commit_cnt    = r_commit_cnt;
  assign overrun_cnt   = r_overrun_cnt;
  assign bad_idx       = r_bad_idx;

endmodule

// File: tb/tb_param_bank.sv
// Scoreboarded bench for param_bank: a driver steps an array-based reference
// model and queues expected outputs; a monitor compares them after each edge.
module tb_param_bank;

  localparam int N = 55;
  localparam int W = N * 8;

  logic           clk;
  logic           reset;
  logic           update_reg;
  logic [5:0]     idx;
  logic [7:0]     read_data;
  logic           pc_ready;
  logic           frame_start;
  logic [5:0]     rd_idx;
  logic [7:0]     rd_data;
  logic [W-1:0]   params_flat;
  logic           commit_pending;
  logic           frame_applied;
  logic [7:0]     commit_cnt;
  logic [3:0]     overrun_cnt;
  logic           bad_idx;

  param_bank #(.NUM_REGS(N), .IDX_W(6)) dut (
    .clk(clk), .reset(reset), .update_reg(update_reg), .idx(idx),
    .read_data(read_data), .pc_ready(pc_ready), .frame_start(frame_start),
    .rd_idx(rd_idx), .rd_data(rd_data), .params_flat(params_flat),
    .commit_pending(commit_pending), .frame_applied(frame_applied),
    .commit_cnt(commit_cnt), .overrun_cnt(overrun_cnt), .bad_idx(bad_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] flat;
    logic [7:0]   rd;
    logic         pend;
    logic         fa;
    logic [7:0]   cc;
    logic [3:0]   oc;
    logic         bad;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int m_sh[N];
  int m_ac[N];
  bit m_pend;
  int m_cc;
  int m_oc;
  bit m_bad;

  task automatic cmp(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic upd, input logic [5:0] ix,
                      input logic [7:0] d, input logic pc, input logic fs,
                      input logic [5:0] ri);
    exp_t e;
    bit   commit;
    int   rdv;
    reset = rst; update_reg = upd; idx = ix; read_data = d;
    pc_ready = pc; frame_start = fs; rd_idx = ri;
    if (rst) begin
      foreach (m_sh[k]) begin m_sh[k] = 0; m_ac[k] = 0; end
      m_pend = 0; m_cc = 0; m_oc = 0; m_bad = 0;
      commit = 0; rdv = 0;
    end else begin
      commit = fs && (m_pend || pc);
      rdv = (int'(ri) < N) ? m_ac[ri] : 0;
      if (commit) foreach (m_ac[k]) m_ac[k] = m_sh[k];
      if (upd) begin
        if (int'(ix) < N) m_sh[ix] = int'(d);
        else              m_bad = 1;
      end
      if (pc && m_pend && !commit && m_oc < 15) m_oc++;
      if (commit)  m_pend = 0;
      else if (pc) m_pend = 1;
      if (commit) m_cc = (m_cc + 1) % 256;
    end
    for (int k = 0; k < N; k++) e.flat[k*8 +: 8] = 8'(m_ac[k]);
    e.rd = 8'(rdv); e.pend = m_pend; e.fa = commit;
    e.cc = 8'(m_cc); e.oc = 4'(m_oc); e.bad = m_bad;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [5:0] ri);
    for (int i = 0; i < n; i++) step(0, 0, 6'd0, 8'd0, 0, 0, ri);
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("params_flat",    params_flat,        e.flat);
        cmp("rd_data",        W'(rd_data),        W'(e.rd));
        cmp("commit_pending", W'(commit_pending), W'(e.pend));
        cmp("frame_applied",  W'(frame_applied),  W'(e.fa));
        cmp("commit_cnt",     W'(commit_cnt),     W'(e.cc));
        cmp("overrun_cnt",    W'(overrun_cnt),    W'(e.oc));
        cmp("bad_idx",        W'(bad_idx),        W'(e.bad));
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1; update_reg = 0; idx = 0; read_data = 0;
    pc_ready = 0; frame_start = 0; rd_idx = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1, 0, 6'd0, 8'd0, 0, 0, 6'd0);
    idle(1, 6'd0);
    cmp("reset_flat", params_flat, '0);

    // Basic packet
    for (int i = 0; i < N; i++) step(0, 1, 6'(i), 8'(8'h10 + i), 0, 0, 6'd0);
    step(0, 0, 6'd0, 8'd0, 1, 0, 6'd0);
    idle(3, 6'd0);
    step(0, 0, 6'd0, 8'd0, 0, 1, 6'd0);
    idle(2, 6'd3);
    cmp("basic_byte54", W'(params_flat[54*8 +: 8]), W'(8'h46));
    cmp("basic_cnt",    W'(commit_cnt),             W'(8'd1));
    cmp("basic_rd3",    W'(rd_data),                W'(8'h13));

    // No tearing
    step(0, 1, 6'd5, 8'hAA, 0, 0, 6'd5);
    step(0, 0, 6'd0, 8'd0, 0, 1, 6'd5);
    idle(2, 6'd5);
    cmp("tear_byte5", W'(params_flat[5*8 +: 8]), W'(8'h15));
    step(0, 0, 6'd0, 8'd0, 1, 0, 6'd5);
    step(0, 0, 6'd0, 8'd0, 0, 1, 6'd5);
    idle(2, 6'd5);
    cmp("tear_byte5_new", W'(params_flat[5*8 +: 8]), W'(8'hAA));

    // Simultaneous pc_ready + frame_start, then write + commit
    step(0, 0, 6'd0, 8'd0, 1, 1, 6'd7);
    idle(1, 6'd7);
    cmp("simul_oc",   W'(overrun_cnt),    W'(4'd0));
    cmp("simul_pend", W'(commit_pending), W'(1'b0));
    step(0, 1, 6'd7, 8'h55, 1, 1, 6'd7);
    idle(1, 6'd7);
    cmp("simul_byte7_old", W'(params_flat[7*8 +: 8]), W'(8'h17));
    step(0, 0, 6'd0, 8'd0, 1, 1, 6'd7);
    idle(1, 6'd7);
    cmp("simul_byte7_new", W'(params_flat[7*8 +: 8]), W'(8'h55));

    // Overrun and saturation
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 6'd0, 8'd0, 1, 0, 6'd0);
      idle(1, 6'd0);
    end
    cmp("ovr_cnt2", W'(overrun_cnt),    W'(4'd2));
    cmp("ovr_pend", W'(commit_pending), W'(1'b1));
    step(0, 0, 6'd0, 8'd0, 0, 1, 6'd0);
    idle(1, 6'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 6'd0, 8'd0, 1, 0, 6'd0);
    cmp("ovr_sat", W'(overrun_cnt), W'(4'd15));
    step(0, 0, 6'd0, 8'd0, 0, 1, 6'd0);

    // Boundary: bad indices, out-of-range read, counter wrap, reset while pending
    step(0, 1, 6'd55, 8'hEE, 0, 0, 6'd60);
    step(0, 1, 6'd63, 8'hEE, 0, 0, 6'd60);
    idle(2, 6'd60);
    cmp("bad_sticky", W'(bad_idx), W'(1'b1));
    cmp("rd_oob",     W'(rd_data), W'(8'h00));
    for (int i = 0; i < 256; i++) step(0, 0, 6'd0, 8'd0, 1, 1, 6'd1);
    step(0, 1, 6'd9, 8'h99, 1, 0, 6'd0);
    step(1, 0, 6'd0, 8'd0, 0, 0, 6'd0);
    step(0, 0, 6'd0, 8'd0, 0, 1, 6'd9);
    idle(1, 6'd9);
    cmp("rst_pend_cnt", W'(commit_cnt), W'(8'd0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0),
           6'($urandom_range(0, 63)),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 24) == 0),
           6'($urandom_range(0, 63)));
    end
    idle(2, 6'd0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    cmp("queue_drained", W'(q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
